ff_pipe: RTL

Parametrised elastic register pipeline: the multi-stage, multi-channel generalisation of the single write-enabled flip-flop. It carries NUM_CH signed channels through DEPTH register stages under a valid/ready handshake. Bubbles collapse, backpressure stalls only the stages that are full, and a synchronous flush empties the pipe. It sits between datapath blocks (e.g. detector/equaliser stages) wherever retiming with flow control is needed.

---
 rtl/ff_pipe.sv | 108 ++++++++++
 1 files changed

// File: rtl/ff_pipe.sv
// ff_pipe: elastic register pipeline carrying NUM_CH signed channels through
// DEPTH register stages under a valid/ready handshake. Bubbles collapse,
// backpressure stalls only full stages, and a synchronous flush empties it.
//
// Ports:
//   Clk_CI       clock, all state updates on posedge
//   Rst_RI       asynchronous active-high reset (clears valids, data, count)
//   Flush_SI     synchronous flush, discards all held beats
//   InValid_SI   upstream beat valid
//   InReady_SO   pipe can accept a beat this cycle
//   D_DI         packed input beat, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   OutValid_SO  output beat valid
//   OutReady_SI  downstream accepts output beat
//   Q_DO         packed output beat (registered), same packing as D_DI
//   Cnt_DO       number of valid beats held (0..DEPTH)
module ff_pipe #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RI,
  input  logic                         Flush_SI,
  input  logic                         InValid_SI,
  output logic                         InReady_SO,
  input  logic [NUM_CH*DATA_WIDTH-1:0] D_DI,
  output logic                         OutValid_SO,
  input  logic                         OutReady_SI,
  output logic [NUM_CH*DATA_WIDTH-1:0] Q_DO,
  output logic [CNT_W-1:0]             Cnt_DO
);

  localparam int unsigned W = NUM_CH * DATA_WIDTH;

  logic [DEPTH-1:0] r_v;
  logic [W-1:0]     r_data [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_vin;
  logic [W-1:0]     w_din [DEPTH];
  logic             w_acc;
  logic             w_in_hs;
  logic             w_out_hs;

  // Ready chain, walked from the output side back to the input side through
  // a running term so no vector bit depends on another bit of itself.
  always_comb begin
    w_rdy = '0;
    w_acc = OutReady_SI;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      w_acc             = ~r_v[DEPTH-1-j] | w_acc;
      w_rdy[DEPTH-1-j]  = w_acc;
    end
  end

  // Source of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    w_vin    = '0;
    w_vin[0] = InValid_SI & ~Flush_SI;
    w_din[0] = D_DI;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_vin[i] = r_v[i-1];
      w_din[i] = r_data[i-1];
    end
  end

  assign InReady_SO  = w_rdy[0] & ~Flush_SI;
  assign OutValid_SO = r_v[DEPTH-1] & ~Flush_SI;
  assign Q_DO        = r_data[DEPTH-1];
  assign Cnt_DO      = r_cnt;

  assign w_in_hs  = InValid_SI & InReady_SO;
  assign w_out_hs = OutValid_SO & OutReady_SI;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_v   <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (Flush_SI) begin
          r_v[i] <= 1'b0;
        end else if (w_rdy[i]) begin
          r_v[i] <= w_vin[i];
        end
        // Data only moves with a valid beat, so bubbles never toggle it;
        // a flush leaves data untouched.
        if (w_rdy[i] && w_vin[i] && !Flush_SI) begin
          r_data[i] <= w_din[i];
        end
      end

      if (Flush_SI) begin
        r_cnt <= '0;
      end else if (w_in_hs && !w_out_hs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_out_hs && !w_in_hs) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule
